// File: rtl/ysyx_25060173_pkg.sv
// Shared types and constants for the ysyx_25060173 instruction fetch unit.
//   XLEN          : address/data width (32 only)
//   RESET_PC_DEF  : default PC after reset
//   NOP_INST      : addi x0,x0,0, presented in place of a faulting fetch
//   ifu_state_e   : 3-bit IFU FSM encoding
//   inst_pkt_t    : instruction + PC payload handed to the decoder
package ysyx_25060173_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DROP = 3'd3,
    ST_HOLD = 3'd4
  } ifu_state_e;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } inst_pkt_t;

  // True when an address is not word aligned.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_25060173_pc_reg.sv
// Program counter register.
//   clk, rst_n   : clock, asynchronous active-low reset (loads RESET_PC)
//   redirect_en  : load redirect_pc (wins over advance_en)
//   redirect_pc  : new PC
//   advance_en   : pc <= pc + 4 (wraps modulo 2^XLEN)
//   pc           : current PC
module ysyx_25060173_pc_reg
  import ysyx_25060173_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance_en,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_q, pc_d;

  // Redirect has priority; otherwise advance or hold.
  always_comb begin
    pc_d = pc_q;
    if (redirect_en) begin
      pc_d = redirect_pc;
    end else if (advance_en) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/ysyx_25060173_ifu.sv
// Instruction fetch unit: owns the PC, keeps at most one imem request outstanding
// and hands each fetched word plus its PC to the decoder over valid/ready.
// Address width is the package XLEN (32 only).
//   clk, rst_n                 : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr  : fetch request channel (addr = pc)
//   imem_resp_valid/rdata      : fetch response, one per accepted request
//   redirect_valid/pc          : PC change from execute, highest priority
//   inst_valid/ready/inst/pc   : instruction channel to the decoder (registered)
//   fetch_fault                : misaligned redirect target (registered)
// Optional feature macro IFU_ALIGN_CHK_EN: a misaligned redirect target yields a
// nop with fetch_fault=1 instead of a fetch. Without it the low two bits of
// redirect_pc are cleared and fetch_fault stays 0.
module ysyx_25060173_ifu
  import ysyx_25060173_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault
);

  ifu_state_e      state_q, state_d;
  inst_pkt_t       pkt_q, pkt_d;
  logic            inst_valid_q, inst_valid_d;
  logic            fault_q, fault_d;
  logic            pc_redirect, pc_advance;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redirect_tgt;
  logic            redirect_fault;

`ifdef IFU_ALIGN_CHK_EN
  assign redirect_tgt   = redirect_pc;
  assign redirect_fault = is_misaligned(redirect_pc);
`else
  assign redirect_tgt   = redirect_pc & ~XLEN'(3);
  assign redirect_fault = 1'b0;
`endif

  ysyx_25060173_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect_en(pc_redirect),
    .redirect_pc(redirect_tgt),
    .advance_en (pc_advance),
    .pc         (pc)
  );

  // Next state, request control and output register updates.
  always_comb begin
    state_d        = state_q;
    pkt_d          = pkt_q;
    inst_valid_d   = inst_valid_q;
    fault_d        = fault_q;
    pc_redirect    = 1'b0;
    pc_advance     = 1'b0;
    imem_req_valid = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        // A same-cycle redirect withholds the request; it is reissued at the new pc.
        imem_req_valid = ~redirect_valid;
        if (imem_req_valid && imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          pkt_d        = '{inst: imem_rdata, pc: pc};
          inst_valid_d = 1'b1;
          state_d      = ST_HOLD;
        end
      end
      ST_DROP: begin
        if (imem_resp_valid) state_d = ST_REQ;
      end
      ST_HOLD: begin
        if (inst_ready) begin
          pc_advance   = 1'b1;
          inst_valid_d = 1'b0;
          fault_d      = 1'b0;
          state_d      = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect overrides everything except the post-reset IDLE cycle.
    if (redirect_valid && (state_q != ST_IDLE)) begin
      pc_redirect  = 1'b1;
      pc_advance   = 1'b0;
      inst_valid_d = 1'b0;
      fault_d      = 1'b0;
      pkt_d        = pkt_q;
      case (state_q)
        ST_WAIT, ST_DROP: state_d = imem_resp_valid ? ST_REQ : ST_DROP;
        default:          state_d = ST_REQ;
      endcase
      if (redirect_fault) begin
        pkt_d        = '{inst: NOP_INST, pc: redirect_pc};
        inst_valid_d = 1'b1;
        fault_d      = 1'b1;
        state_d      = ST_HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pkt_q        <= '0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pkt_q        <= pkt_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign imem_addr   = pc;
  assign inst_valid  = inst_valid_q;
  assign inst        = pkt_q.inst;
  assign inst_pc     = pkt_q.pc;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_ysyx_25060173_ifu.sv
// Self-checking bench for ysyx_25060173_ifu. Memory returns addr ^ 32'h5555_0000.
// Stimulus pushes expected request addresses, expected decoder transfers and
// point checks into queues; one monitor process evaluates them at each negedge.
module tb_ysyx_25060173_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  ysyx_25060173_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  localparam int C_REQV    = 0;
  localparam int C_ADDR    = 1;
  localparam int C_IV      = 2;
  localparam int C_INST    = 3;
  localparam int C_IPC     = 4;
  localparam int C_FAULT   = 5;
  localparam int C_TIMEOUT = 6;
  localparam int C_AQ_LEFT = 7;
  localparam int C_IQ_LEFT = 8;

  typedef struct {
    int          sel;
    logic [31:0] exp;
  } dchk_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } iexp_t;

  dchk_t       dq[$];
  logic [31:0] aq[$];
  iexp_t       iq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stale_cyc = -10;
  int mem_lat = 1;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  initial begin
    logic        fire;
    logic [31:0] faddr, paddr;
    logic        pend;
    int          cnt;
    imem_resp_valid = 1'b0;
    imem_rdata      = '0;
    pend            = 1'b0;
    cnt             = 0;
    paddr           = '0;
    forever begin
      @(negedge clk);
      fire  = rst_n && imem_req_valid && imem_req_ready;
      faddr = imem_addr;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (!rst_n) pend = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          imem_resp_valid = 1'b1;
          imem_rdata      = paddr ^ 32'h5555_0000;
          pend            = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
      if (fire) begin
        if (mem_lat <= 1) begin
          imem_resp_valid = 1'b1;
          imem_rdata      = faddr ^ 32'h5555_0000;
        end else begin
          pend  = 1'b1;
          cnt   = mem_lat - 1;
          paddr = faddr;
        end
      end
      if (cyc == stale_cyc) begin
        imem_resp_valid = 1'b1;
        imem_rdata      = 32'hDEAD_BEEF;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  function automatic string sel_name(input int sel);
    case (sel)
      C_REQV:    return "imem_req_valid";
      C_ADDR:    return "imem_addr";
      C_IV:      return "inst_valid";
      C_INST:    return "inst";
      C_IPC:     return "inst_pc";
      C_FAULT:   return "fetch_fault";
      C_TIMEOUT: return "wait_timeout";
      C_AQ_LEFT: return "req_queue_left";
      default:   return "inst_queue_left";
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    dchk_t       d;
    iexp_t       e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (dq.size() > 0) begin
        d = dq.pop_front();
        case (d.sel)
          C_REQV:    act = {31'b0, imem_req_valid};
          C_ADDR:    act = imem_addr;
          C_IV:      act = {31'b0, inst_valid};
          C_INST:    act = inst;
          C_IPC:     act = inst_pc;
          C_FAULT:   act = {31'b0, fetch_fault};
          C_TIMEOUT: act = 32'd1;
          C_AQ_LEFT: act = 32'(aq.size());
          default:   act = 32'(iq.size());
        endcase
        cmp(sel_name(d.sel), act, d.exp);
      end
      if (rst_n && imem_req_valid && imem_req_ready) begin
        if (aq.size() == 0) cmp("unexpected_req_addr", imem_addr, 32'hFFFF_FFFF);
        else cmp("req_addr", imem_addr, aq.pop_front());
      end
      if (rst_n && inst_valid && inst_ready) begin
        if (iq.size() == 0) begin
          cmp("unexpected_inst_pc", inst_pc, 32'hFFFF_FFFF);
        end else begin
          e = iq.pop_front();
          cmp("xfer_inst_pc", inst_pc, e.pc);
          cmp("xfer_inst", inst, e.inst);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic expect_sig(input int sel, input logic [31:0] exp);
    dchk_t d;
    d.sel = sel;
    d.exp = exp;
    dq.push_back(d);
  endtask

  task automatic expect_inst(input logic [31:0] pc, input logic [31:0] w);
    iexp_t e;
    e.pc   = pc;
    e.inst = w;
    iq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns at posedge+1 following the first negedge with inst_valid high.
  task automatic wait_hold();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (inst_valid) ok = 1'b1;
    end
    if (!ok) expect_sig(C_TIMEOUT, 32'd0);
    step();
  endtask

  // Returns at posedge+1 just after a request handshake.
  task automatic wait_req();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) ok = 1'b1;
    end
    if (!ok) expect_sig(C_TIMEOUT, 32'd0);
    step();
  endtask

  task automatic consume_one();
    inst_ready = 1'b1;
    wait_hold();
    inst_ready = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    step();
    step();

    // Reset values
    expect_sig(C_REQV, 32'd0);
    expect_sig(C_IV, 32'd0);
    expect_sig(C_INST, 32'd0);
    expect_sig(C_IPC, 32'd0);
    expect_sig(C_FAULT, 32'd0);
    expect_sig(C_ADDR, 32'h8000_0000);
    step();

    // Sequential fetch with a 1-cycle memory
    aq.push_back(32'h8000_0000);
    aq.push_back(32'h8000_0004);
    aq.push_back(32'h8000_0008);
    aq.push_back(32'h8000_000C);
    expect_inst(32'h8000_0000, 32'hD555_0000);
    expect_inst(32'h8000_0004, 32'hD555_0004);
    expect_inst(32'h8000_0008, 32'hD555_0008);
    rst_n = 1'b1;
    consume_one();
    consume_one();
    consume_one();

    // Decoder stalls in HOLD for 5 cycles
    wait_hold();
    for (int i = 0; i < 5; i++) begin
      expect_sig(C_IV, 32'd1);
      expect_sig(C_INST, 32'hD555_000C);
      expect_sig(C_IPC, 32'h8000_000C);
      expect_sig(C_REQV, 32'd0);
      step();
    end

    // Memory not ready: request held at pc+4
    imem_req_ready = 1'b0;
    expect_inst(32'h8000_000C, 32'hD555_000C);
    aq.push_back(32'h8000_0010);
    consume_one();
    for (int i = 0; i < 2; i++) begin
      expect_sig(C_REQV, 32'd1);
      expect_sig(C_ADDR, 32'h8000_0010);
      step();
    end

    // Redirect while waiting on a 3-cycle response
    mem_lat        = 3;
    imem_req_ready = 1'b1;
    wait_req();
    aq.push_back(32'h8000_0100);
    expect_inst(32'h8000_0100, 32'hD555_0100);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    mem_lat        = 1;
    expect_sig(C_REQV, 32'd0);
    expect_sig(C_IV, 32'd0);
    aq.push_back(32'h8000_0104);
    expect_inst(32'h8000_0104, 32'hD555_0104);
    consume_one();

    // Redirect coincident with inst_ready in HOLD
    aq.push_back(32'h8000_0200);
    wait_hold();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    step();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    expect_sig(C_IV, 32'd0);
    expect_sig(C_REQV, 32'd1);
    expect_sig(C_ADDR, 32'h8000_0200);
    expect_inst(32'h8000_0200, 32'hD555_0200);
    wait_hold();

    // Reset asserted in WAIT, stale response after release
    mem_lat = 3;
    aq.push_back(32'h8000_0204);
    consume_one();
    wait_req();
    rst_n     = 1'b0;
    stale_cyc = cyc + 2;
    expect_sig(C_REQV, 32'd0);
    expect_sig(C_IV, 32'd0);
    expect_sig(C_INST, 32'd0);
    expect_sig(C_IPC, 32'd0);
    expect_sig(C_FAULT, 32'd0);
    expect_sig(C_ADDR, 32'h8000_0000);
    step();
    step();
    rst_n   = 1'b1;
    mem_lat = 1;
    aq.push_back(32'h8000_0000);
    aq.push_back(32'h8000_0004);
    expect_inst(32'h8000_0000, 32'hD555_0000);
    expect_sig(C_IV, 32'd0);
    step();
    expect_sig(C_IV, 32'd0);
    expect_sig(C_REQV, 32'd1);
    expect_sig(C_ADDR, 32'h8000_0000);
    consume_one();
    wait_hold();

`ifdef IFU_ALIGN_CHK_EN
    // Misaligned redirect produces a faulting nop without a fetch
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    expect_sig(C_IV, 32'd1);
    expect_sig(C_INST, 32'h0000_0013);
    expect_sig(C_IPC, 32'h8000_0102);
    expect_sig(C_FAULT, 32'd1);
    expect_sig(C_REQV, 32'd0);
    step();
    expect_sig(C_FAULT, 32'd1);
    expect_sig(C_REQV, 32'd0);
    expect_inst(32'h8000_0102, 32'h0000_0013);
    aq.push_back(32'h8000_0106);
    consume_one();
    expect_sig(C_FAULT, 32'd0);
    expect_sig(C_IV, 32'd0);
    wait_hold();
`else
    // Misaligned redirect target has its low bits cleared
    aq.push_back(32'h8000_0300);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0301;
    step();
    redirect_valid = 1'b0;
    expect_sig(C_FAULT, 32'd0);
    expect_sig(C_IV, 32'd0);
    wait_hold();
    expect_sig(C_IPC, 32'h8000_0300);
    expect_sig(C_INST, 32'hD555_0300);
    expect_sig(C_FAULT, 32'd0);
`endif

    step();
    step();
    expect_sig(C_AQ_LEFT, 32'd0);
    expect_sig(C_IQ_LEFT, 32'd0);
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
